// File: rtl/sprite_mover_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sprite_pkg
// Brief    : Shared types, display defaults and axis-step helpers for the
//            sprite mover and renderer.
// Revision : 1.0 - initial release
// ============================================================================
package sprite_pkg;

    typedef logic [10:0] coord_t;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        CALC   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    typedef struct packed {
        coord_t pos;
        logic   dir;   // 1 = moving towards larger coordinates
    } axis_t;

    localparam int unsigned c_h_active = 640;
    localparam int unsigned c_v_active = 480;
    localparam int unsigned c_sprite_w = 32;
    localparam int unsigned c_sprite_h = 32;

    // Bounce step; all math is 12-bit so wrap-around cannot hide an overshoot.
    function automatic axis_t axis_auto(input coord_t pos, input logic dir,
                                        input logic [11:0] step,
                                        input logic [11:0] lim);
        axis_t       res;
        logic [11:0] w_pos;
        logic [11:0] w_sum;
        logic [11:0] w_dif;
        w_pos = {1'b0, pos};
        w_sum = w_pos + step;
        w_dif = w_pos - step;
        res   = '{pos: pos, dir: dir};
        if (dir) begin
            if (w_sum >= lim) res = '{pos: lim[10:0], dir: 1'b0};
            else              res = '{pos: w_sum[10:0], dir: 1'b1};
        end else begin
            if (w_pos <= step) res = '{pos: 11'd0, dir: 1'b1};
            else               res = '{pos: w_dif[10:0], dir: 1'b0};
        end
        return res;
    endfunction

    function automatic coord_t axis_manual(input coord_t pos, input logic dec,
                                           input logic inc,
                                           input logic [11:0] step,
                                           input logic [11:0] lim);
        coord_t      res;
        logic [11:0] w_pos;
        logic [11:0] w_sum;
        logic [11:0] w_dif;
        w_pos = {1'b0, pos};
        w_sum = w_pos + step;
        w_dif = w_pos - step;
        res   = pos;
        if (dec && !inc) begin
            res = (w_pos < step) ? 11'd0 : w_dif[10:0];
        end else if (inc && !dec) begin
            res = (w_sum > lim) ? lim[10:0] : w_sum[10:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_mover_if.sv
`default_nettype none
// ============================================================================
// Module   : sprite_mover_if
// Brief    : Control inputs and per-frame sprite outputs of the sprite mover.
//            SPRITE_MOVER_PAUSE_EN adds the pause input.
// Revision : 1.0 - initial release
// ============================================================================
interface sprite_mover_if;
    import sprite_pkg::*;

    logic        frame_tick;
    logic        mode;
    logic [3:0]  btn;        // {up, down, left, right}
`ifdef SPRITE_MOVER_PAUSE_EN
    logic        pause;
`endif
    coord_t      POSX;
    coord_t      POSY;
    logic [1:0]  per;

    modport master (
`ifdef SPRITE_MOVER_PAUSE_EN
        output pause,
`endif
        output frame_tick, mode, btn,
        input  POSX, POSY, per
    );

    modport slave (
`ifdef SPRITE_MOVER_PAUSE_EN
        input  pause,
`endif
        input  frame_tick, mode, btn,
        output POSX, POSY, per
    );

endinterface
`default_nettype wire

// File: rtl/sprite_mover_btn_sync.sv
`default_nettype none
// ============================================================================
// Module   : btn_sync
// Brief    : Parameterized-width two-flop synchronizer, async active-low reset.
// Revision : 1.0 - initial release
// ============================================================================
module btn_sync #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic [WIDTH-1:0] d,
    output logic      [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/sprite_mover.sv
`default_nettype none
// ============================================================================
// Module   : sprite_mover
// Brief    : Per-frame sprite position/animation control (auto bounce or
//            buttons). SPRITE_MOVER_PAUSE_EN enables the pause input.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int unsigned H_ACTIVE = c_h_active,
    parameter int unsigned V_ACTIVE = c_v_active,
    parameter int unsigned SPRITE_W = c_sprite_w,
    parameter int unsigned SPRITE_H = c_sprite_h,
    parameter int unsigned STEP     = 2,
    parameter int unsigned ANIM_DIV = 8,
    parameter int unsigned X_INIT   = 304,
    parameter int unsigned Y_INIT   = 224
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    sprite_mover_if.slave   bus
);

    localparam logic [11:0] c_x_max  = 12'(H_ACTIVE - SPRITE_W);
    localparam logic [11:0] c_y_max  = 12'(V_ACTIVE - SPRITE_H);
    localparam logic [11:0] c_step   = 12'(STEP);
    localparam coord_t      c_x_init = 11'(X_INIT);
    localparam coord_t      c_y_init = 11'(Y_INIT);
    localparam int          c_anim_w = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
    localparam logic [c_anim_w-1:0] c_anim_last = c_anim_w'(ANIM_DIV - 1);

`ifdef SPRITE_MOVER_PAUSE_EN
    localparam int c_sync_w = 5;
    logic [c_sync_w-1:0] w_sync_in;
    assign w_sync_in = {bus.pause, bus.btn};
`else
    localparam int c_sync_w = 4;
    logic [c_sync_w-1:0] w_sync_in;
    assign w_sync_in = bus.btn;
`endif

    logic [c_sync_w-1:0] w_sync_out;

    btn_sync #(.WIDTH(c_sync_w)) u_btn_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (w_sync_in),
        .q     (w_sync_out)
    );

    state_t               r_state, w_next_state;
    logic [3:0]           r_btn_l;
    logic                 r_mode_l;
    logic                 r_pause_l;
    coord_t               r_posx, r_posy, r_sh_x, r_sh_y;
    logic                 r_dir_x, r_dir_y, r_sh_dir_x, r_sh_dir_y;
    logic [1:0]           r_per, r_sh_per;
    logic [c_anim_w-1:0]  r_anim, r_sh_anim;

    axis_t                w_ax, w_ay;
    logic                 w_advance;
    logic [1:0]           w_nper;
    logic [c_anim_w-1:0]  w_nanim;
    logic                 w_pause_now;

`ifdef SPRITE_MOVER_PAUSE_EN
    assign w_pause_now = w_sync_out[4];
`else
    assign w_pause_now = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            WAIT:    if (bus.frame_tick) w_next_state = CALC;
            CALC:    w_next_state = COMMIT;
            COMMIT:  w_next_state = WAIT;
            default: w_next_state = WAIT;
        endcase
    end

    // Next-frame values derived from committed state and the latched inputs.
    always_comb begin
        w_ax      = '{pos: r_posx, dir: r_dir_x};
        w_ay      = '{pos: r_posy, dir: r_dir_y};
        w_advance = 1'b1;
        w_nanim   = r_anim;
        w_nper    = r_per;
        if (r_mode_l) begin
            w_ax.pos  = axis_manual(r_posx, r_btn_l[1], r_btn_l[0], c_step, c_x_max);
            w_ay.pos  = axis_manual(r_posy, r_btn_l[3], r_btn_l[2], c_step, c_y_max);
            w_advance = (w_ax.pos != r_posx) || (w_ay.pos != r_posy);
        end else begin
            w_ax = axis_auto(r_posx, r_dir_x, c_step, c_x_max);
            w_ay = axis_auto(r_posy, r_dir_y, c_step, c_y_max);
        end
        if (w_advance) begin
            if (r_anim == c_anim_last) begin
                w_nanim = '0;
                w_nper  = r_per + 2'd1;
            end else begin
                w_nanim = r_anim + 1'b1;
            end
        end
        if (r_pause_l) begin
            w_ax    = '{pos: r_posx, dir: r_dir_x};
            w_ay    = '{pos: r_posy, dir: r_dir_y};
            w_nanim = r_anim;
            w_nper  = r_per;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_l    <= '0;
            r_mode_l   <= 1'b0;
            r_pause_l  <= 1'b0;
            r_posx     <= c_x_init;
            r_posy     <= c_y_init;
            r_dir_x    <= 1'b1;
            r_dir_y    <= 1'b1;
            r_per      <= '0;
            r_anim     <= '0;
            r_sh_x     <= c_x_init;
            r_sh_y     <= c_y_init;
            r_sh_dir_x <= 1'b1;
            r_sh_dir_y <= 1'b1;
            r_sh_per   <= '0;
            r_sh_anim  <= '0;
        end else begin
            unique case (r_state)
                WAIT: begin
                    if (bus.frame_tick) begin
                        r_btn_l   <= w_sync_out[3:0];
                        r_mode_l  <= bus.mode;
                        r_pause_l <= w_pause_now;
                    end
                end
                CALC: begin
                    r_sh_x     <= w_ax.pos;
                    r_sh_y     <= w_ay.pos;
                    r_sh_dir_x <= w_ax.dir;
                    r_sh_dir_y <= w_ay.dir;
                    r_sh_per   <= w_nper;
                    r_sh_anim  <= w_nanim;
                end
                COMMIT: begin
                    r_posx  <= r_sh_x;
                    r_posy  <= r_sh_y;
                    r_dir_x <= r_sh_dir_x;
                    r_dir_y <= r_sh_dir_y;
                    r_per   <= r_sh_per;
                    r_anim  <= r_sh_anim;
                end
                default: ;
            endcase
        end
    end

    assign bus.POSX = r_posx;
    assign bus.POSY = r_posy;
    assign bus.per  = r_per;

endmodule
`default_nettype wire

// File: tb/tb_sprite_mover.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprite_mover
// Brief    : Directed self-checking bench for sprite_mover.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_mover;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    sprite_mover_if bus ();

    sprite_mover u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Tick sampled at E0; outputs settle after E2, sampled on the next negedge.
    task automatic do_tick();
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic set_btn(input logic [3:0] b);
        @(negedge clk) bus.btn = b;
        repeat (3) @(negedge clk);
    endtask

    task automatic idle_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.mode       = 1'b0;
        bus.btn        = 4'b0000;
`ifdef SPRITE_MOVER_PAUSE_EN
        bus.pause      = 1'b0;
`endif
        // Reset held while ticks arrive
        repeat (2) @(negedge clk);
        repeat (3) begin
            @(negedge clk) bus.frame_tick = 1'b1;
            @(negedge clk) bus.frame_tick = 1'b0;
        end
        check("rst_posx", 32'(bus.POSX), 304);
        check("rst_posy", 32'(bus.POSY), 224);
        check("rst_per",  32'(bus.per),  0);
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_posx", 32'(bus.POSX), 304);
        check("idle_posy", 32'(bus.POSY), 224);

        // Latency of the first auto tick
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        check("lat_e0_posx", 32'(bus.POSX), 304);
        @(negedge clk);
        check("lat_e1_posx", 32'(bus.POSX), 304);
        @(negedge clk);
        check("lat_e2_posx", 32'(bus.POSX), 306);
        check("lat_e2_posy", 32'(bus.POSY), 226);

        // Auto bounce and animation
        for (int k = 2; k <= 153; k++) begin
            do_tick();
            case (k)
                7:   check("anim_t7_per",  32'(bus.per), 0);
                8:   check("anim_t8_per",  32'(bus.per), 1);
                15:  check("anim_t15_per", 32'(bus.per), 1);
                16:  check("anim_t16_per", 32'(bus.per), 2);
                32:  check("anim_t32_per", 32'(bus.per), 0);
                112: check("bnc_t112_posy", 32'(bus.POSY), 448);
                113: check("bnc_t113_posy", 32'(bus.POSY), 446);
                152: check("bnc_t152_posx", 32'(bus.POSX), 608);
                153: begin
                    check("bnc_t153_posx", 32'(bus.POSX), 606);
                    check("bnc_t153_posy", 32'(bus.POSY), 366);
                    check("bnc_t153_per",  32'(bus.per),  3);
                end
                default: ;
            endcase
        end

        // Manual mode from a clean reset
        idle_reset();
        bus.mode = 1'b1;
        set_btn(4'b0010);
        repeat (152) do_tick();
        check("man_left_posx", 32'(bus.POSX), 0);
        check("man_left_per",  32'(bus.per),  3);
        repeat (5) do_tick();
        check("man_clamp_posx", 32'(bus.POSX), 0);
        check("man_clamp_posy", 32'(bus.POSY), 224);
        check("man_clamp_per",  32'(bus.per),  3);
        set_btn(4'b0001);
        repeat (7) do_tick();
        check("man_r7_posx", 32'(bus.POSX), 14);
        check("man_r7_per",  32'(bus.per),  3);
        do_tick();
        check("man_r8_posx", 32'(bus.POSX), 16);
        check("man_r8_per",  32'(bus.per),  0);
        set_btn(4'b0011);
        do_tick();
        check("man_lr_posx", 32'(bus.POSX), 16);
        check("man_lr_per",  32'(bus.per),  0);
        set_btn(4'b1000);
        do_tick();
        check("man_up_posy", 32'(bus.POSY), 222);
        check("man_up_posx", 32'(bus.POSX), 16);

        // Reset asserted while the FSM is in CALC
        bus.mode = 1'b0;
        set_btn(4'b0000);
        @(negedge clk) bus.frame_tick = 1'b1;
        @(posedge clk);
        #2;
        bus.frame_tick = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mid_rst_posx", 32'(bus.POSX), 304);
        check("mid_rst_posy", 32'(bus.POSY), 224);
        check("mid_rst_per",  32'(bus.per),  0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_posx", 32'(bus.POSX), 304);
        do_tick();
        check("post_rst_tick_posx", 32'(bus.POSX), 306);
        check("post_rst_tick_posy", 32'(bus.POSY), 226);

        // Second tick arriving during COMMIT is dropped
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        @(negedge clk) bus.frame_tick = 1'b1;
        @(negedge clk) bus.frame_tick = 1'b0;
        repeat (4) @(negedge clk);
        check("coll_posx", 32'(bus.POSX), 308);
        check("coll_posy", 32'(bus.POSY), 228);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
- Upstream control stage for the sprite renderer.
- Produces the sprite's top-left coordinate (POSX, POSY) and its 2-bit frame selector (per) once per video frame, either by auto-bouncing inside the active area or from four push-buttons.
- All outputs are registered and change only in a single commit cycle after frame_tick, so the renderer sees stable values for the whole frame.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- SPRITE_W, 32, sprite width in pixels
- SPRITE_H, 32, sprite height in pixels
- STEP, 2, pixels moved per frame per axis
- ANIM_DIV, 8, frames per animation step (>=1)
- X_INIT, 304, reset POSX
- Y_INIT, 224, reset POSY

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse at start of vertical blanking
- mode  in  1  0 = auto bounce, 1 = manual buttons
- btn  in  4  raw asynchronous buttons {up, down, left, right}
- POSX  out  11  sprite X, 0..H_ACTIVE-SPRITE_W
- POSY  out  11  sprite Y, 0..V_ACTIVE-SPRITE_H
- per  out  2  sprite/animation frame select

Behaviour:
- Reset (async, rst_n=0): POSX=X_INIT, POSY=Y_INIT, per=0, dir_x=+, dir_y=+, anim counter=0, state=WAIT, synchronizer flops=0.
- Constants: X_MAX=H_ACTIVE-SPRITE_W (608), Y_MAX=V_ACTIVE-SPRITE_H (448). All arithmetic is 12-bit to catch overflow and underflow, then truncated to 11 bits.
- btn passes through a 2-FF synchronizer before use.
- FSM states are WAIT, CALC and COMMIT.
  - WAIT: when frame_tick=1 at edge E0, latch the synchronized btn and mode, then go to CALC.
  - CALC (E1): compute shadow x, y, dir and per, then go to COMMIT.
  - COMMIT (E2): copy the shadow values to the outputs, then go to WAIT.
  - Outputs change after E2, i.e. 2 cycles after the tick edge.
- frame_tick in CALC or COMMIT is ignored; no queuing.
- Auto mode, X axis:
  - dir + : nx=POSX+STEP; if nx>=X_MAX, then nx=X_MAX and dir flips to −.
  - dir − : if POSX<=STEP, then nx=0 and dir flips to +; else nx=POSX−STEP.
  - The Y axis follows the same rules against Y_MAX.
- Manual mode, X axis:
  - left alone: nx=max(POSX−STEP,0).
  - right alone: nx=min(POSX+STEP,X_MAX).
  - left and right together, or neither: X unchanged.
  - Y uses up/down with the same rules. dir registers are held.
- Animation: the anim counter increments on each frame in which "advance" is true, and wraps at ANIM_DIV−1.
  - Each wrap does per=per+1 mod 4.
  - Auto mode: advance is always true.
  - Manual mode: advance is true only if X or Y actually changed that frame.
- Mode change takes effect at the next latched tick. dir registers are preserved across mode changes.
- Reset asserted in CALC or COMMIT: shadow values are discarded and outputs return immediately to reset values.

Optional Feature:
- Macro: SPRITE_MOVER_PAUSE_EN.
- Defined: adds input port pause (1 bit), sampled with the button synchronizer. When pause=1 at the tick, the FSM still walks CALC/COMMIT but POSX, POSY, per, dir and the anim counter all hold.
- Undefined: no pause port; behaviour as above.

Decomposition:
- Package sprite_pkg holds:
  - coord_t (logic [10:0]) and the state enum {WAIT, CALC, COMMIT}.
  - H_ACTIVE/V_ACTIVE/SPRITE_W/SPRITE_H defaults, shared with the renderer.
- One sub-module, btn_sync: a parameterized-width 2-FF synchronizer with async active-low reset.

Test Plan:
- Reset: rst_n=0 with frame_ticks present -> POSX=304, POSY=224, per=0, constant. Release, no tick -> values unchanged.
- Latency: mode=0, one tick -> POSX=306, POSY=226 visible after the 2nd rising edge following the tick edge, with the old values before that.
- Bounce: mode=0, 152 ticks -> POSX=608 and dir_x flips; tick 153 -> POSX=606. Tick 112 -> POSY=448; tick 113 -> POSY=446.
- Animation: mode=0, ANIM_DIV=8 -> per goes 0→1 at tick 8 and 1→2 at tick 16; after 32 ticks per=0.
- Manual clamp: mode=1, POSX driven to 0 via left.
  - left held for 5 ticks -> POSX stays 0 and per/anim counter do not advance.
  - left+right held -> POSX unchanged.
  - up held from POSY=224 -> POSY=222.
- Mid-op reset and tick collision:
  - rst_n pulsed low in CALC -> outputs at reset values asynchronously, FSM in WAIT.
  - A second frame_tick during COMMIT -> exactly one update.
